// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, key-reader state encoding and the
// scan-byte to key-vector mapping.
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_WAIT,
    ST_READ,
    ST_STOP
  } key_rd_state_e;

  // Keys k and k+4 live in bits 0 and 4 of scan byte k; other bits are unused.
  function automatic logic [7:0] decode_keys(input logic [31:0] raw);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[i]     = raw[8*i];
      k[i + 4] = raw[8*i + 4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Half-period timer for the TM1638 serial clock: half_done strobes on the last
// cycle of each CLK_DIV-cycle half, phase flips after it (0 = low half).
module tm1638_bit_timer #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic half_done,
  output logic phase
);

  localparam int            CW   = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign half_done = en && (cnt_q == LAST);
  assign phase     = phase_q;

  // clr wins over en so the owner can restart the count on the edge it changes state.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends command 0x42, releases DIO, waits Twait, clocks
// in four scan bytes and publishes them with the decoded 8-key vector.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV  = 25,
  parameter int WAIT_CYC = 100
) (
  input  logic        clk_50M,
  input  logic        rs,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  keys,
  output logic [31:0] keys_raw,
  output logic        valid,
  output logic        tm_clk,
  output logic        tm_stb,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in
);

  localparam int            WW        = $clog2(WAIT_CYC) + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

  key_rd_state_e state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          tm_clk_q, tm_clk_d, tm_stb_q, tm_stb_d;
  logic          dio_out_q, dio_out_d, dio_oe_q, dio_oe_d;
  logic          busy_q, busy_d, valid_q, valid_d;
  logic [7:0]    keys_q, keys_d;
  logic [31:0]   keys_raw_q, keys_raw_d;
  logic          tmr_en, tmr_clr, half_done, phase;

  tm1638_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk_50M),
    .rs        (rs),
    .en        (tmr_en),
    .clr       (tmr_clr),
    .half_done (half_done),
    .phase     (phase)
  );

  // Handshake: start is a single-cycle request honoured only in IDLE (busy=0);
  // busy covers the whole frame and valid pulses once as busy falls.
  // Pin registers hold their value and change only on half/state boundaries.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    shift_d    = shift_q;
    tm_clk_d   = tm_clk_q;
    tm_stb_d   = tm_stb_q;
    dio_out_d  = dio_out_q;
    dio_oe_d   = dio_oe_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    keys_d     = keys_q;
    keys_raw_d = keys_raw_q;
    tmr_en     = 1'b0;
    tmr_clr    = 1'b0;
    bit_nxt    = bit_cnt_q + 5'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START;
          busy_d    = 1'b1;
          tm_stb_d  = 1'b0;
          tm_clk_d  = 1'b1;
          dio_oe_d  = 1'b1;
          dio_out_d = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        tmr_en = 1'b1;
        if (half_done) begin
          state_d   = ST_CMD;
          tmr_clr   = 1'b1;
          tm_clk_d  = 1'b0;
          dio_out_d = CMD_READ_KEYS[0];
        end
      end
      ST_CMD: begin
        tmr_en = 1'b1;
        if (half_done) begin
          if (!phase) begin
            tm_clk_d = 1'b1;
          end else if (bit_cnt_q == 5'd7) begin
            state_d    = ST_WAIT;
            tmr_clr    = 1'b1;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            dio_oe_d   = 1'b0;
            dio_out_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_nxt;
            tm_clk_d  = 1'b0;
            dio_out_d = CMD_READ_KEYS[bit_nxt[2:0]];
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d  = ST_READ;
          tm_clk_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      ST_READ: begin
        tmr_en = 1'b1;
        if (half_done) begin
          if (!phase) begin
            tm_clk_d = 1'b1;
          end else begin
            // Last cycle of the high half: the device's bit has been stable since the fall.
            shift_d = {dio_in, shift_q[31:1]};
            if (bit_cnt_q == 5'd31) begin
              state_d = ST_STOP;
              tmr_clr = 1'b1;
            end else begin
              bit_cnt_d = bit_nxt;
              tm_clk_d  = 1'b0;
            end
          end
        end
      end
      ST_STOP: begin
        tmr_en = 1'b1;
        if (half_done) begin
          state_d    = ST_IDLE;
          tmr_clr    = 1'b1;
          tm_stb_d   = 1'b1;
          busy_d     = 1'b0;
          valid_d    = 1'b1;
          keys_raw_d = shift_q;
          keys_d     = decode_keys(shift_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rs) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      shift_q    <= '0;
      tm_clk_q   <= 1'b1;
      tm_stb_q   <= 1'b1;
      dio_out_q  <= 1'b1;
      dio_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      keys_q     <= '0;
      keys_raw_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      shift_q    <= shift_d;
      tm_clk_q   <= tm_clk_d;
      tm_stb_q   <= tm_stb_d;
      dio_out_q  <= dio_out_d;
      dio_oe_q   <= dio_oe_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      keys_q     <= keys_d;
      keys_raw_q <= keys_raw_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign keys     = keys_q;
  assign keys_raw = keys_raw_q;
  assign tm_clk   = tm_clk_q;
  assign tm_stb   = tm_stb_q;
  assign dio_out  = dio_out_q;
  assign dio_oe   = dio_oe_q;

endmodule

// File: doc/tm1638_key_reader.md
Name: tm1638_key_reader

Overview:
- Bus initiator for the key-scan read transaction of the TM1638 LED/key driver. It is the read-direction counterpart of the existing display-write path.
- On request it drives STB low and clocks out the read-keys command 0x42. It releases DIO, waits the chip's Twait, clocks in 4 scan bytes, and decodes them into an 8-key vector.
- Runs on the 50 MHz system clock and shares the CLK/STB/DIO pins with the display writer. An external arbiter issues `start` only while the writer is idle.

Parameters:
- CLK_DIV, 25: system cycles per half-period of tm_clk (25 gives a 1 MHz serial clock). Legal values ≥1.
- WAIT_CYC, 100: system cycles held between the command's last rising edge and the first read bit (2 µs; must be ≥1 µs).

Ports:
- clk_50M  input  1: system clock.
- rs  input  1: synchronous active-high reset.
- start  input  1: one-cycle request for a read transaction. Ignored while busy=1.
- busy  output  1: high from the cycle after start is accepted through the final STB release.
- keys  output  8: decoded key states, 1 = pressed. Held until the next valid.
- keys_raw  output  32: the four received bytes; byte k is in [8k+7:8k], and the first-received bit is bit 0.
- valid  output  1: one-cycle pulse when keys/keys_raw update.
- tm_clk  output  1: serial clock to the TM1638. Idles high.
- tm_stb  output  1: chip strobe, active low.
- dio_out  output  1: DIO drive value.
- dio_oe  output  1: DIO output enable; 0 = released. The top level builds the tristate; the external pull-up is present.
- dio_in  input  1: DIO pad value. Already synchronised by a 2-flop chain in the top level.

Behaviour:
- Clocking and reset: one clock, clk_50M. Reset rs is synchronous and active-high.
- Reset values: tm_clk=1, tm_stb=1, dio_out=1, dio_oe=0, busy=0, valid=0, keys=0, keys_raw=0. All outputs are registered.
- FSM states: IDLE → START → CMD → WAIT → READ → STOP → IDLE.
- IDLE: start=1 moves to START on the next edge, and busy rises with it.
- START (CLK_DIV cycles): tm_stb=0, tm_clk=1, dio_oe=1, dio_out=1.
- CMD (8 bits of 0x42, LSB first): each bit is a low half then a high half, CLK_DIV cycles each.
  - dio_out changes on the first cycle of the low half.
  - tm_clk rises at the start of the high half; the TM1638 samples on that rising edge.
- WAIT (WAIT_CYC cycles): tm_clk=1, dio_oe=0. DIO stays released from here until STOP ends.
- READ (32 bits, same half-period timing as CMD): the device shifts on the falling edge.
  - dio_in is sampled on the last cycle of each high half, just before tm_clk falls.
  - Samples shift into keys_raw bit j for the j-th received bit.
- STOP (CLK_DIV cycles): tm_clk=1, tm_stb=0. On exit, all of the following happen in the same cycle:
  - tm_stb=1, busy=0, valid=1;
  - keys and keys_raw are loaded from the shift register.
- Transaction length: busy is high for CLK_DIV·(2+16+64)+WAIT_CYC cycles, which is 2150 with the defaults.
- Decode, for k=0..3: keys[k]=byte k bit0 and keys[k+4]=byte k bit4. All other raw bits are ignored by keys.
- start while busy is dropped; no queueing.
- rs during any state: the next edge forces reset values. STB rising mid-frame aborts the transaction on the chip; keys keep their reset value.
- The received-bit counter is 5 bits and the half-period counter is $clog2(CLK_DIV)+1 bits. Neither wraps during a legal frame.

Decomposition:
- Shared package tm1638_pkg holds:
  - CMD_READ_KEYS=8'h42, CMD_WRITE_AUTO=8'h40, CMD_DISP_ON base 8'h88;
  - the state enum for this FSM.
- The writer uses the same command constants.
- One natural sub-module: tm1638_bit_timer, a CLK_DIV half-period counter that emits a half_done strobe and a phase flag. It is shared with the writer.

Test Plan:
- Reset: hold rs 3 cycles → all outputs at their reset values. start held low for 5000 cycles → tm_stb never falls.
- Command shape: one start pulse → tm_stb low. Sampling dio_out on the first 8 tm_clk rising edges yields 0,1,0,0,0,0,1,0 (0x42). dio_oe=0 from WAIT onward. Gap between the 8th rise and the 9th rise ≥ 50+100 cycles.
- Read/decode: device model returns bytes 0x01,0x00,0x10,0x00 → keys_raw=32'h00100001, keys=8'h41. valid is high for exactly 1 cycle, at cycle 2150 after busy rises.
- All keys: model returns 0x11 ×4 → keys=8'hFF. A following frame returning 0x00 ×4 → keys=8'h00.
- start while busy: pulse start at cycle 1000 of a frame → no second frame begins, and busy is low at the expected end cycle.
- Reset mid-READ: assert rs in the 10th read bit → next cycle tm_stb=1, tm_clk=1, busy=0, keys=0, no valid pulse. A fresh start afterwards completes normally. Also repeat the decode test with CLK_DIV=1.
